fifo_sync: RTL

Single-clock, parametrised FIFO: the synchronous successor to the dual-clock pointer-synchronised FIFO used between the CCD readout and the host interface. Both sides run on one clock, so no pointer synchronisers are needed. It adds a fill-level output, programmable almost-full/almost-empty thresholds, a selectable first-word-fall-through (FWFT) read mode, a synchronous flush, and sticky overflow/underflow error flags. It buffers pixel words between the ADC sampling pipeline and the packetiser, which both run in the system clock domain.

---
 rtl/fifo_sync.sv | 123 ++++++++++++
 1 files changed

// File: rtl/fifo_sync.sv
// fifo_sync: single-clock FIFO with fill level, almost-full/almost-empty flags,
// selectable registered or first-word-fall-through read, flush and sticky errors.
module fifo_sync #(
  parameter int data_width   = 16,
  parameter int addr_width   = 8,
  parameter bit fwft         = 1'b0,
  parameter int afull_level  = (1 << addr_width) - 4,
  parameter int aempty_level = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic [data_width-1:0] wdata,
  input  logic                  winc,
  output logic                  wfull,
  output logic                  walmost_full,
  input  logic                  rinc,
  output logic [data_width-1:0] rdata,
  output logic                  rempty,
  output logic                  ralmost_empty,
  output logic [addr_width:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int depth = 1 << addr_width;
  localparam logic [addr_width:0] depth_c  = (addr_width+1)'(depth);
  localparam logic [addr_width:0] afull_c  = (addr_width+1)'(afull_level);
  localparam logic [addr_width:0] aempty_c = (addr_width+1)'(aempty_level);

  // Handshake: winc/rinc are single-cycle requests sampled on the rising edge.
  // A write is accepted only when !wfull, a read only when !rempty; a refused
  // request has no effect other than raising overflow/underflow.

  logic [data_width-1:0] mem [depth];
  logic [addr_width-1:0] waddr;
  logic [addr_width-1:0] raddr;
  logic                  wr_ok;
  logic                  rd_ok;
  logic                  out_load;
  logic [data_width-1:0] out_data;

  assign wfull         = (count == depth_c);
  assign walmost_full  = (count >= afull_c);
  assign ralmost_empty = (count <= aempty_c);

  assign wr_ok = winc && !wfull  && !flush;
  assign rd_ok = rinc && !rempty && !flush;

  if (fwft) begin : g_fwft
    // ov marks a valid head word in rdata; count includes it, so the RAM
    // holds count - ov words.
    logic                ov;
    logic [addr_width:0] ram_words;
    logic                ram_rd;
    logic                bypass;

    assign ram_words = count - {{addr_width{1'b0}}, ov};
    assign rempty    = !ov;
    assign ram_rd    = !flush && (!ov || rd_ok) && (ram_words != '0);
    // The only word left is being popped while a new one arrives: forward it
    // straight into the output register so sustained traffic at count=1 has
    // no bubble. The word is still written to RAM so both pointers advance.
    assign bypass    = rd_ok && wr_ok && (ram_words == '0);
    assign out_load  = ram_rd || bypass;
    assign out_data  = bypass ? wdata : mem[raddr];

    always_ff @(posedge clk) begin
      if (rst || flush) begin
        ov <= 1'b0;
      end else if (out_load) begin
        ov <= 1'b1;
      end else if (rd_ok) begin
        ov <= 1'b0;
      end
    end
  end else begin : g_std
    assign rempty   = (count == '0);
    assign out_load = rd_ok;
    assign out_data = mem[raddr];
  end

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      waddr     <= '0;
      raddr     <= '0;
      count     <= '0;
      rdata     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      waddr <= '0;
      raddr <= '0;
      count <= '0;
    end else begin
      if (wr_ok) begin
        waddr <= waddr + 1'b1;
      end
      if (out_load) begin
        raddr <= raddr + 1'b1;
        rdata <= out_data;
      end
      if (wr_ok && !rd_ok) begin
        count <= count + 1'b1;
      end else if (rd_ok && !wr_ok) begin
        count <= count - 1'b1;
      end
      if (winc && wfull) begin
        overflow <= 1'b1;
      end
      if (rinc && rempty) begin
        underflow <= 1'b1;
      end
    end
  end

endmodule
